// File: rtl/mmio_pkg.sv
// Shared definitions for the data-memory-port responders: register offsets,
// RV32I load/store size encoding and the load lane-extract helper.
package mmio_pkg;

   localparam logic [7:0] OFF_IN_STATE = 8'h00;
   localparam logic [7:0] OFF_IN_RISE  = 8'h04;
   localparam logic [7:0] OFF_MICROS   = 8'h08;
   localparam logic [7:0] OFF_MILLIS   = 8'h0C;

   typedef enum logic [2:0] {
      F3_B  = 3'b000,
      F3_H  = 3'b001,
      F3_W  = 3'b010,
      F3_BU = 3'b100,
      F3_HU = 3'b101
   } funct3_e;

   // Byte lane from addr[1:0], half lane from addr[1]; unknown sizes read as zero.
   function automatic logic [31:0] load_extract(input logic [31:0] word,
                                                input logic [1:0]  lane,
                                                input logic [2:0]  f3);
      logic [7:0]  b;
      logic [15:0] h;
      case (lane)
         2'd0:    b = word[7:0];
         2'd1:    b = word[15:8];
         2'd2:    b = word[23:16];
         default: b = word[31:24];
      endcase
      h = lane[1] ? word[31:16] : word[15:0];
      case (f3)
         F3_W:    load_extract = word;
         F3_B:    load_extract = {{24{b[7]}}, b};
         F3_BU:   load_extract = {24'h0, b};
         F3_H:    load_extract = {{16{h[15]}}, h};
         F3_HU:   load_extract = {16'h0, h};
         default: load_extract = 32'h0;
      endcase
   endfunction

endpackage

// File: rtl/mmio_input_responder_debounce_ch.sv
// One input channel: 2-flop synchronizer, stability counter and debounced
// state, plus a one-cycle rise indication aligned with the state update.
module debounce_ch #(
   parameter int unsigned LIMIT = 24
) (
   input  logic clk,
   input  logic reset,
   input  logic pin,
   output logic state,
   output logic rise
);
   localparam int unsigned CW = (LIMIT > 1) ? $clog2(LIMIT) : 1;
   localparam logic [CW-1:0] TC = CW'(LIMIT - 1);

   logic          sync1_q, sync1_d;
   logic          sync2_q, sync2_d;
   logic          state_q, state_d;
   logic [CW-1:0] cnt_q, cnt_d;

   always_comb begin
      sync1_d = pin;
      sync2_d = sync1_q;
      state_d = state_q;
      cnt_d   = cnt_q;
      if (sync2_q == state_q) begin
         cnt_d = '0;
      end else if (cnt_q == TC) begin
         state_d = ~state_q;
         cnt_d   = '0;
      end else begin
         cnt_d = cnt_q + 1'b1;
      end
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         sync1_q <= 1'b0;
         sync2_q <= 1'b0;
         state_q <= 1'b0;
         cnt_q   <= '0;
      end else begin
         sync1_q <= sync1_d;
         sync2_q <= sync2_d;
         state_q <= state_d;
         cnt_q   <= cnt_d;
      end
   end

   assign state = state_q;
   assign rise  = state_d & ~state_q;

endmodule

// File: rtl/mmio_input_responder.sv
// Input-direction MMIO responder: debounced switches, sticky rise flags and
// free-running microsecond/millisecond counters on the data-memory bus.
module mmio_input_responder
   import mmio_pkg::*;
#(
   parameter logic [31:0] BASE_ADDR   = 32'hFFFF_FF00,
   parameter int unsigned N_IN        = 4,
   parameter int unsigned CLK_HZ      = 12_000_000,
   parameter int unsigned DEBOUNCE_US = 5000
) (
   input  logic            clk,
   input  logic            reset,
   input  logic            write_mem,
   input  logic [2:0]      funct3,
   input  logic [31:0]     address,
   input  logic [31:0]     write_data,
   input  logic [N_IN-1:0] inputs,
   output logic            hit,
   output logic [31:0]     read_data_clocked
);
   localparam int unsigned US_DIV  = CLK_HZ / 1_000_000;
   localparam int unsigned DEB_CYC = DEBOUNCE_US * US_DIV;
   localparam int unsigned US_W    = $clog2(US_DIV);
   localparam int unsigned MS_DIV  = 1000;
   localparam int unsigned MS_W    = $clog2(MS_DIV);

   logic [US_W-1:0] us_pre_q, us_pre_d;
   logic [MS_W-1:0] ms_pre_q, ms_pre_d;
   logic [31:0]     micros_q, micros_d;
   logic [31:0]     millis_q, millis_d;
   logic [31:0]     rise_q, rise_d;
   logic [31:0]     read_data_q, read_data_d;
   logic [N_IN-1:0] in_state;
   logic [N_IN-1:0] in_rise;
   logic            us_tick;
   logic            ms_tick;
   logic            rise_clr_en;
   logic [31:0]     rise_clr;
   logic [31:0]     sel_word;

   for (genvar i = 0; i < N_IN; i++) begin : g_ch
      debounce_ch #(.LIMIT(DEB_CYC)) u_ch (
         .clk   (clk),
         .reset (reset),
         .pin   (inputs[i]),
         .state (in_state[i]),
         .rise  (in_rise[i])
      );
   end

   assign hit = (address[31:8] == BASE_ADDR[31:8]);

   always_comb begin
      us_tick  = (us_pre_q == US_W'(US_DIV - 1));
      ms_tick  = us_tick && (ms_pre_q == MS_W'(MS_DIV - 1));
      us_pre_d = us_tick ? '0 : us_pre_q + 1'b1;
      ms_pre_d = ms_pre_q;
      micros_d = micros_q;
      millis_d = millis_q;
      if (us_tick) begin
         micros_d = micros_q + 32'd1;
         ms_pre_d = ms_tick ? '0 : ms_pre_q + 1'b1;
      end
      if (ms_tick) begin
         millis_d = millis_q + 32'd1;
      end
   end

   // Flags are kept 32 wide so the clear mask needs no slicing; bits at and
   // above N_IN are never set and stay zero.
   always_comb begin
      rise_clr_en = hit && write_mem && (funct3 == F3_W) && (address[7:0] == OFF_IN_RISE);
      rise_clr    = rise_clr_en ? write_data : 32'h0;
      rise_d      = (rise_q & ~rise_clr) | 32'(in_rise);
   end

   always_comb begin
      case ({address[7:2], 2'b00})
         OFF_IN_STATE: sel_word = 32'(in_state);
         OFF_IN_RISE:  sel_word = rise_q;
         OFF_MICROS:   sel_word = micros_q;
         OFF_MILLIS:   sel_word = millis_q;
         default:      sel_word = 32'h0;
      endcase
      read_data_d = hit ? load_extract(sel_word, address[1:0], funct3) : 32'h0;
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         us_pre_q    <= '0;
         ms_pre_q    <= '0;
         micros_q    <= '0;
         millis_q    <= '0;
         rise_q      <= '0;
         read_data_q <= '0;
      end else begin
         us_pre_q    <= us_pre_d;
         ms_pre_q    <= ms_pre_d;
         micros_q    <= micros_d;
         millis_q    <= millis_d;
         rise_q      <= rise_d;
         read_data_q <= read_data_d;
      end
   end

   assign read_data_clocked = read_data_q;

endmodule

// File: tb/tb_mmio_input_responder.sv
// Bench for mmio_input_responder: behavioural model checked every cycle,
// directed scenarios with literal expectations, then randomized traffic.
module tb_mmio_input_responder;
   localparam int          N_IN   = 4;
   localparam int          CLK_HZ = 12_000_000;
   localparam int          DEB_US = 2;
   localparam int          DIV    = CLK_HZ / 1_000_000;
   localparam int          DEB    = DEB_US * DIV;
   localparam logic [31:0] BASE   = 32'hFFFF_FF00;
   localparam logic [2:0]  LB = 3'b000, LH = 3'b001, LW = 3'b010, LBU = 3'b100, LHU = 3'b101;

   logic            clk = 1'b0;
   logic            reset = 1'b1;
   logic            write_mem = 1'b0;
   logic [2:0]      funct3 = LW;
   logic [31:0]     address = 32'h0;
   logic [31:0]     write_data = 32'h0;
   logic [N_IN-1:0] inputs = '0;
   logic            hit;
   logic [31:0]     read_data_clocked;

   int n_vec = 0;
   int n_err = 0;

   mmio_input_responder #(
      .BASE_ADDR(BASE), .N_IN(N_IN), .CLK_HZ(CLK_HZ), .DEBOUNCE_US(DEB_US)
   ) dut (
      .clk(clk), .reset(reset), .write_mem(write_mem), .funct3(funct3),
      .address(address), .write_data(write_data), .inputs(inputs),
      .hit(hit), .read_data_clocked(read_data_clocked)
   );

   always #5 clk = ~clk;

   // ---------------- behavioural model ----------------
   logic [31:0]     m_cyc = 0;   // clock edges since reset released
   logic [31:0]     m_off = 0;   // MICROS offset introduced by preloads
   logic [N_IN-1:0] m_p1 = '0, m_p2 = '0, m_st = '0, m_rise = '0, m_set;
   int              m_run [N_IN];
   logic [31:0]     m_rd = 0;
   bit              m_valid = 0;

   function automatic logic m_hit(input logic [31:0] a);
      return a[31:8] == BASE[31:8];
   endfunction

   function automatic logic [31:0] m_micros();
      return m_cyc / 32'(DIV) + m_off;
   endfunction

   function automatic logic [31:0] m_millis();
      return (m_cyc / 32'(DIV)) / 32'd1000;
   endfunction

   function automatic logic [31:0] m_load(input logic [31:0] a, input logic [2:0] f);
      logic [31:0] w;
      logic [7:0]  b;
      logic [15:0] h;
      if (!m_hit(a)) return 32'h0;
      case (a[7:2])
         6'd0:    w = 32'(m_st);
         6'd1:    w = 32'(m_rise);
         6'd2:    w = m_micros();
         6'd3:    w = m_millis();
         default: w = 32'h0;
      endcase
      b = 8'(w >> (8 * a[1:0]));
      h = 16'(w >> (16 * a[1]));
      case (f)
         LW:      return w;
         LB:      return {{24{b[7]}}, b};
         LBU:     return {24'h0, b};
         LH:      return {{16{h[15]}}, h};
         LHU:     return {16'h0, h};
         default: return 32'h0;
      endcase
   endfunction

   initial forever begin
      @(posedge clk);
      if (reset) begin
         m_cyc = 0; m_off = 0; m_p1 = '0; m_p2 = '0; m_st = '0; m_rise = '0; m_rd = 0;
         for (int i = 0; i < N_IN; i++) m_run[i] = 0;
         m_valid = 1;
      end else begin
         m_rd  = m_load(address, funct3);
         m_set = '0;
         for (int i = 0; i < N_IN; i++) begin
            if (m_p2[i] != m_st[i]) begin
               m_run[i]++;
               if (m_run[i] == DEB) begin
                  m_st[i]  = ~m_st[i];
                  m_run[i] = 0;
                  m_set[i] = m_st[i];
               end
            end else begin
               m_run[i] = 0;
            end
         end
         if (write_mem && m_hit(address) && funct3 == LW && address[7:0] == 8'h04)
            m_rise = m_rise & ~write_data[N_IN-1:0];
         m_rise = m_rise | m_set;
         m_p2   = m_p1;
         m_p1   = inputs;
         m_cyc  = m_cyc + 1;
      end
   end

   task automatic check(input string nm, input logic [31:0] got, input logic [31:0] expv);
      n_vec++;
      if (got !== expv) begin
         n_err++;
         $display("FAIL %s: got %h expected %h at %0t", nm, got, expv, $time);
      end
   endtask

   initial forever begin
      @(posedge clk);
      #1;
      if (m_valid) begin
         check("model_hit", {31'b0, hit}, {31'b0, m_hit(address)});
         check("model_rd", read_data_clocked, m_rd);
      end
   end

   // ---------------- directed helpers ----------------
   task automatic do_reset(input int n);
      @(negedge clk);
      reset = 1'b1;
      repeat (n) @(posedge clk);
      @(negedge clk);
      reset = 1'b0;
   endtask

   task automatic preload(input logic [31:0] v);
      dut.micros_q = v;
      m_off = v - m_cyc / 32'(DIV);
   endtask

   task automatic ld(input logic [31:0] a, input logic [2:0] f, input string nm, input logic [31:0] expv);
      @(negedge clk);
      write_mem = 1'b0; address = a; funct3 = f;
      @(posedge clk);
      #1;
      check(nm, read_data_clocked, expv);
   endtask

   task automatic ld_pre(input logic [31:0] v, input logic [31:0] a, input logic [2:0] f,
                         input string nm, input logic [31:0] expv);
      @(negedge clk);
      preload(v);
      write_mem = 1'b0; address = a; funct3 = f;
      @(posedge clk);
      #1;
      check(nm, read_data_clocked, expv);
   endtask

   task automatic st(input logic [31:0] a, input logic [2:0] f, input logic [31:0] d);
      @(negedge clk);
      write_mem = 1'b1; address = a; funct3 = f; write_data = d;
      @(posedge clk);
      @(negedge clk);
      write_mem = 1'b0;
   endtask

   initial begin
      #1_000_000;
      $display("FAIL watchdog: time %0t reached, required completion earlier", $time);
      $fatal(1);
   end

   // ---------------- stimulus ----------------
   initial begin
      int idx;
      repeat (3) @(posedge clk);
      @(negedge clk);
      reset = 1'b0;

      ld(BASE + 32'h00, LW, "rst_in_state", 32'h0);
      ld(BASE + 32'h04, LW, "rst_in_rise", 32'h0);
      ld(BASE + 32'h08, LW, "rst_micros", 32'h0);
      ld(BASE + 32'h0C, LW, "rst_millis", 32'h0);
      ld(32'h0000_0100, LW, "outside_rd", 32'h0);
      check("outside_hit", {31'b0, hit}, 32'h0);

      // timebase: MILLIS steps on the same edge MICROS goes 999 -> 1000
      do_reset(2);
      address = BASE + 32'h08; funct3 = LW;
      repeat (11999) @(posedge clk);
      #1 check("micros_999", read_data_clocked, 32'd999);
      @(negedge clk) address = BASE + 32'h0C;
      @(posedge clk);
      #1 check("millis_0", read_data_clocked, 32'd0);
      @(negedge clk) address = BASE + 32'h08;
      @(posedge clk);
      #1 check("micros_1000", read_data_clocked, 32'd1000);
      @(negedge clk) address = BASE + 32'h0C;
      @(posedge clk);
      #1 check("millis_1", read_data_clocked, 32'd1);

      // debounce latency on inputs[2]
      @(negedge clk);
      address = BASE + 32'h00;
      inputs[2] = 1'b1;
      repeat (26) @(posedge clk);
      #1 check("state_before", read_data_clocked, 32'h0);
      @(posedge clk);
      #1 check("state_after26", read_data_clocked, 32'h4);
      ld(BASE + 32'h04, LW, "rise_set", 32'h4);

      // short glitch on inputs[1]
      @(negedge clk) inputs[1] = 1'b1;
      repeat (10) @(negedge clk);
      inputs[1] = 1'b0;
      repeat (40) @(negedge clk);
      ld(BASE + 32'h00, LW, "glitch_state", 32'h4);
      ld(BASE + 32'h04, LW, "glitch_rise", 32'h4);

      st(BASE + 32'h04, LW, 32'h4);
      ld(BASE + 32'h04, LW, "w1c_clear", 32'h0);

      // new rise landing on the W1C edge
      @(negedge clk) inputs[2] = 1'b0;
      repeat (30) @(negedge clk);
      inputs[2] = 1'b1;
      repeat (25) @(posedge clk);
      st(BASE + 32'h04, LW, 32'h4);
      ld(BASE + 32'h04, LW, "set_wins", 32'h4);
      st(BASE + 32'h04, LB, 32'hFF);
      ld(BASE + 32'h04, LW, "sb_ignored", 32'h4);
      st(BASE + 32'h00, LW, 32'h0);
      ld(BASE + 32'h00, LW, "ro_store_ignored", 32'h4);

      // sub-word loads of MICROS
      ld_pre(32'h8000_12FF, BASE + 32'h08, LB,  "lb_08",  32'hFFFF_FFFF);
      ld_pre(32'h8000_12FF, BASE + 32'h08, LBU, "lbu_08", 32'h0000_00FF);
      ld_pre(32'h8000_12FF, BASE + 32'h0A, LHU, "lhu_0a", 32'h0000_8000);
      ld_pre(32'h8000_12FF, BASE + 32'h0A, LH,  "lh_0a",  32'hFFFF_8000);
      ld_pre(32'h8000_12FF, BASE + 32'h09, LBU, "lbu_09", 32'h0000_0012);
      ld_pre(32'h8000_12FF, BASE + 32'h08, 3'b011, "f3_undef", 32'h0);

      // MICROS wrap
      do_reset(2);
      preload(32'hFFFF_FFFF);
      address = BASE + 32'h08; funct3 = LW;
      repeat (12) @(posedge clk);
      #1 check("wrap_pre", read_data_clocked, 32'hFFFF_FFFF);
      @(posedge clk);
      #1 check("wrap_zero", read_data_clocked, 32'h0);
      ld(BASE + 32'h0C, LW, "wrap_millis", 32'h0);

      // reset in the middle of a pending debounce
      @(negedge clk) inputs = 4'b0001;
      repeat (15) @(negedge clk);
      reset = 1'b1;
      repeat (3) @(negedge clk);
      reset = 1'b0;
      address = BASE + 32'h00; funct3 = LW;
      repeat (26) @(posedge clk);
      #1 check("midrst_before", read_data_clocked, 32'h0);
      @(posedge clk);
      #1 check("midrst_after", read_data_clocked, 32'h1);
      ld(BASE + 32'h04, LW, "held_rise", 32'h1);

      // randomized traffic
      for (int k = 0; k < 4000; k++) begin
         @(negedge clk);
         if (k == 2000) reset = 1'b1;
         if (k == 2003) reset = 1'b0;
         if ($urandom_range(0, 39) == 0) begin
            idx = $urandom_range(0, N_IN - 1);
            inputs[idx] = ~inputs[idx];
         end
         if ($urandom_range(0, 3) == 0) address = $urandom;
         else address = {BASE[31:8], 8'($urandom_range(0, 19))};
         funct3     = 3'($urandom);
         write_mem  = ($urandom_range(0, 7) == 0);
         write_data = $urandom;
         if ($urandom_range(0, 15) == 0) begin
            address = BASE + 32'h04; funct3 = LW; write_mem = 1'b1;
         end
      end
      @(negedge clk) write_mem = 1'b0;
      repeat (5) @(posedge clk);
      #2;
      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule

// File: doc/mmio_input_responder.md
Name: mmio_input_responder

Overview:
- Memory-mapped responder on the core's data-memory port for the input direction: switches/buttons in, timebase out to software.
- Sits beside `memory` on the same address/funct3/read-data bus and answers accesses inside its address window.
- Provides synchronized, debounced inputs, sticky rising-edge flags, and free-running microsecond/millisecond counters.
- The top level muxes its read data onto the result path when `hit` is asserted.

Parameters:
- BASE_ADDR, 32'hFFFF_FF00, window base; window is 256 bytes, decoded on addr[31:8].
- N_IN, 4, number of external inputs (1..32).
- CLK_HZ, 12_000_000, clock frequency; CLK_HZ/1_000_000 must be an integer ≥ 2.
- DEBOUNCE_US, 5000, required stable time, in microseconds, before a debounced input changes.

Ports:
- clk  in  1  system clock.
- reset  in  1  asynchronous, active-high reset.
- write_mem  in  1  store strobe, same meaning as at `memory`.
- funct3  in  3  access size/sign (RV32I load/store encoding).
- address  in  32  byte address for both read and write.
- write_data  in  32  store data (rs2v).
- inputs  in  N_IN  raw asynchronous pins.
- hit  out  1  address is inside the window; combinational.
- read_data_clocked  out  32  registered load data, valid one cycle after the address is presented.

Behaviour:
- Reset:
  - Sync flops, debounced state, edge flags, prescalers, MICROS, MILLIS and read_data_clocked all clear to 0.
  - An input held high through reset yields a rise flag once it has debounced.
- Register map (offset = address[7:0]):
  - 0x00 IN_STATE, RO: debounced state in bits [N_IN-1:0], upper bits 0.
  - 0x04 IN_RISE, R/W1C: sticky rising-edge flags of the debounced state.
  - 0x08 MICROS, RO, 32-bit.
  - 0x0C MILLIS, RO, 32-bit.
  - All other offsets read 0; writes to them are ignored.
- Input path:
  - Each input passes through a 2-flop synchronizer.
  - A debounce counter resets whenever the synced value equals the debounced state, otherwise increments.
  - When the counter reaches DEBOUNCE_US*(CLK_HZ/1_000_000)-1, the debounced state toggles and the counter clears.
  - Total latency from pin to state = 2 + DEBOUNCE cycles.
- Edge flags:
  - A 0→1 transition of the debounced state sets IN_RISE[i] in the same cycle the state updates.
  - A store (write_mem=1, hit=1, funct3=010, offset 0x04) clears each bit where write_data is 1.
  - Set and clear in the same cycle: set wins.
- Timebase:
  - The µs prescaler counts 0..CLK_HZ/1_000_000-1; on terminal count MICROS increments.
  - The ms prescaler counts 0..999 µs ticks; on terminal MILLIS increments in the same cycle as the MICROS increment.
  - Both counters wrap modulo 2^32 with no flag.
- Stores: only SW (funct3=010) is honoured. SB/SH and stores to RO registers are ignored.
- Loads:
  - On every cycle, read_data_clocked <= selected word processed per funct3, or 0 if hit=0.
  - The value is registered from the pre-edge register contents, so a same-cycle W1C is not yet visible.
  - LW returns the word.
  - LB/LBU select byte address[1:0]; LH/LHU select half address[1]. Sign- or zero-extend per funct3.
  - Undefined funct3 returns 0.
- Reset mid-operation: all state returns to reset values immediately (asynchronous); a pending debounce is discarded.

Decomposition:
- Shared package mmio_pkg:
  - Register offset constants (OFF_IN_STATE, OFF_IN_RISE, OFF_MICROS, OFF_MILLIS).
  - funct3 enum for load/store sizes, shared with `memory`.
- One sub-module, debounce_ch: synchronizer, counter and state for a single input, instantiated N_IN times via generate.
- Prescalers, register file and read mux stay in the top of this block.

Test Plan (CLK_HZ=12_000_000, DEBOUNCE_US=2 → 24 cycles):
- Reset release, then LW 0xFFFF_FF00/04/08/0C → 0,0,0,0 one cycle later; hit=0 at 0x0000_0100 and read_data_clocked=0.
- Run 12,000 cycles after reset → MICROS=1000 and MILLIS=1; MILLIS steps exactly when MICROS goes 999→1000.
- inputs[2] rises and is held → IN_STATE=0x4 and IN_RISE=0x4 exactly 26 cycles later.
  - A 10-cycle glitch on inputs[1] → no change.
- IN_RISE=0x4, SW 0x4 to 0xFFFF_FF04 → next LW returns 0.
  - Repeat with a new rise of bit 2 landing on the W1C cycle → flag stays 1.
- MICROS=0x8000_12FF:
  - LB offset 0x08 → 0xFFFF_FFFF.
  - LBU → 0x0000_00FF.
  - LHU at 0x0A → 0x0000_8000.
  - LH at 0x0A → 0xFFFF_8000.
- Preload MICROS near 0xFFFF_FFFF (force) → wraps to 0 with no other side effect.
  - Assert reset mid-debounce → IN_STATE stays 0 and the counter restarts after release.
